counter_scheduler: RTL and testbench

//  Shares one WIDTH-bit up-counter among NREQ requesters, each asking for a timed run of req_len+1 cycles.

---
 rtl/counter_sched_pkg.sv | 7 +
 rtl/counter_scheduler_if.sv | 29 ++
 rtl/counter_scheduler_rr_arbiter.sv | 29 ++
 rtl/counter_scheduler.sv | 85 ++++++++
 tb/tb_counter_scheduler.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: shared FSM encoding and default sizes for counter_scheduler.
//   Contents: state_e (S_IDLE/S_RUN), NREQ_DEF, WIDTH_DEF.
package counter_sched_pkg;
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;
  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 4;
endpackage

// File: rtl/counter_scheduler_if.sv
// counter_scheduler_if: request/grant/count bundle between requesters and counter_scheduler.
//   req      requester -> scheduler  level request per requester
//   req_len  requester -> scheduler  terminal count per requester, slice i = [i*WIDTH +: WIDTH]
//   gnt      scheduler -> requester  one-hot counter owner
//   done     scheduler -> requester  one-hot one-cycle completion pulse
//   cnt      scheduler -> requester  current count
//   busy     scheduler -> requester  run active
//   pause    requester -> scheduler  only when COUNTER_SCHED_PAUSE_EN is defined
interface counter_scheduler_if
  import counter_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) ();
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      cnt;
  logic                  busy;
`ifdef COUNTER_SCHED_PAUSE_EN
  logic                  pause;
  modport master (output req, req_len, pause, input gnt, done, cnt, busy);
  modport slave  (input req, req_len, pause, output gnt, done, cnt, busy);
`else
  modport master (output req, req_len, input gnt, done, cnt, busy);
  modport slave  (input req, req_len, output gnt, done, cnt, busy);
`endif
endinterface

// File: rtl/counter_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr_i+1 with wrap.
//   req_masked_i  in   NREQ  eligible requests
//   ptr_i         in   IW    index of the last owner
//   pick_o        out  NREQ  one-hot winner (0 when nothing eligible)
//   idx_o         out  IW    winner index
//   valid_o       out  1     any request eligible
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_masked_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] pick_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);
  logic [NREQ-1:0] rot;
  int off, sum;
  // Rotating the doubled vector puts requester ptr_i+1 at bit 0, so the lowest set bit is the winner.
  always_comb begin
    rot = NREQ'({req_masked_i, req_masked_i} >> (int'(ptr_i) + 1));
    off = 0;
    for (int k = NREQ - 1; k >= 0; k--) if (rot[k]) off = k;
    sum = int'(ptr_i) + 1 + off;
    idx_o = IW'(sum >= NREQ ? sum - NREQ : sum);
    valid_o = |req_masked_i;
    pick_o = valid_o ? NREQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/counter_scheduler.sv
// counter_scheduler: one shared up-counter handed out round-robin for timed runs of req_len+1 cycles.
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset
//   bus    counter_scheduler_if.slave (req, req_len, gnt, done, cnt, busy, pause)
//   Optional: COUNTER_SCHED_PAUSE_EN adds bus.pause, which freezes an active run.
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk,
  input logic reset,
  counter_scheduler_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, pick_idx;
  logic [WIDTH-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d, pick;
  logic busy_q, busy_d, any_req, hold, owner_req, term;
`ifdef COUNTER_SCHED_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif
  // ptr_q is the current owner during a run.
  assign owner_req = bus.req[ptr_q];
  assign term = cnt_q == len_q;
  // A requester still seeing its done pulse is masked so a stale req is not re-granted.
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_masked_i(bus.req & ~done_q),
    .ptr_i(ptr_q),
    .pick_o(pick),
    .idx_o(pick_idx),
    .valid_o(any_req)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q <= IW'(NREQ - 1);
      len_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  // Abort (owner drops req) leaves RUN regardless of terminal count or pause.
  always_comb
    state_d = (state_q == S_IDLE) ? (any_req ? S_RUN : S_IDLE)
            : (!owner_req || (term && !hold)) ? S_IDLE : S_RUN;
  always_comb begin
    ptr_d = ptr_q;
    len_d = len_q;
    cnt_d = '0;
    gnt_d = '0;
    done_d = '0;
    busy_d = state_d == S_RUN;
    if (state_q == S_IDLE) begin
      if (any_req) begin
        gnt_d = pick;
        ptr_d = pick_idx;
        len_d = bus.req_len[int'(pick_idx)*WIDTH +: WIDTH];
      end
    end else if (state_d == S_RUN) begin
      gnt_d = gnt_q;
      cnt_d = hold ? cnt_q : cnt_q + WIDTH'(1);
    end else begin
      done_d = owner_req ? gnt_q : '0;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.done = done_q;
  assign bus.cnt = cnt_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: scoreboard bench for counter_scheduler (expected per-cycle outputs queued, then compared).
module tb_counter_scheduler;
  import counter_sched_pkg::*;
  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] done;
    logic [3:0] cnt;
    logic       busy;
  } obs_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  obs_t q[$];
  obs_t e, got;
  counter_scheduler_if #(.NREQ(4), .WIDTH(4)) bus ();
  counter_scheduler #(.NREQ(4), .WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic obs_t mk(logic [3:0] g, logic [3:0] d, logic [3:0] c, logic b);
    return {g, d, c, b};
  endfunction
  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    bus.req_len = '0;
`ifdef COUNTER_SCHED_PAUSE_EN
    bus.pause = 1'b0;
`endif
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
  task automatic test_reset();
    int c = 0;
    bus.req = '0;
    bus.req_len = '0;
`ifdef COUNTER_SCHED_PAUSE_EN
    bus.pause = 1'b0;
`endif
    #1;
    e = mk(4'b0000, 4'b0000, 4'd0, 1'b0);
    got = {bus.gnt, bus.done, bus.cnt, bus.busy};
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL reset_state got %b_%b_%h_%b required %b_%b_%h_%b", got.gnt, got.done, got.cnt, got.busy, e.gnt, e.done, e.cnt, e.busy); end
    do_reset();
    bus.req = 4'b0001;
    bus.req_len = 16'h0009;
    for (int i = 0; i < 6; i++) q.push_back(mk(4'b0001, 4'b0000, 4'(i), 1'b1));
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      got = {bus.gnt, bus.done, bus.cnt, bus.busy};
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL reset_prerun cyc %0d got %b_%b_%h_%b required %b_%b_%h_%b", c, got.gnt, got.done, got.cnt, got.busy, e.gnt, e.done, e.cnt, e.busy); end
      c++;
    end
    #2 reset = 1'b1;
    q.push_back(mk(4'b0000, 4'b0000, 4'd0, 1'b0));
    q.push_back(mk(4'b0000, 4'b0000, 4'd0, 1'b0));
    #1;
    e = q.pop_front();
    got = {bus.gnt, bus.done, bus.cnt, bus.busy};
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL reset_async got %b_%b_%h_%b required %b_%b_%h_%b", got.gnt, got.done, got.cnt, got.busy, e.gnt, e.done, e.cnt, e.busy); end
    @(posedge clk); #1;
    e = q.pop_front();
    got = {bus.gnt, bus.done, bus.cnt, bus.busy};
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL reset_held got %b_%b_%h_%b required %b_%b_%h_%b", got.gnt, got.done, got.cnt, got.busy, e.gnt, e.done, e.cnt, e.busy); end
    reset = 1'b0;
    bus.req = '0;
  endtask
  task automatic test_basic();
    int c = 0;
    do_reset();
    bus.req = 4'b0001;
    bus.req_len = 16'h0003;
    for (int i = 0; i < 4; i++) q.push_back(mk(4'b0001, 4'b0000, 4'(i), 1'b1));
    q.push_back(mk(4'b0000, 4'b0001, 4'd0, 1'b0));
    q.push_back(mk(4'b0000, 4'b0000, 4'd0, 1'b0));
    q.push_back(mk(4'b0000, 4'b0000, 4'd0, 1'b0));
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      got = {bus.gnt, bus.done, bus.cnt, bus.busy};
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL basic cyc %0d got %b_%b_%h_%b required %b_%b_%h_%b", c, got.gnt, got.done, got.cnt, got.busy, e.gnt, e.done, e.cnt, e.busy); end
      c++;
      if (c == 5) bus.req = '0;
    end
  endtask
  task automatic test_round_robin();
    int c = 0;
    logic [3:0] oh;
    do_reset();
    bus.req = 4'b1111;
    bus.req_len = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << (i % 4);
      q.push_back(mk(oh, 4'b0000, 4'd0, 1'b1));
      q.push_back(mk(4'b0000, oh, 4'd0, 1'b0));
    end
    q.push_back(mk(4'b0000, 4'b0000, 4'd0, 1'b0));
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      got = {bus.gnt, bus.done, bus.cnt, bus.busy};
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL round_robin cyc %0d got %b_%b_%h_%b required %b_%b_%h_%b", c, got.gnt, got.done, got.cnt, got.busy, e.gnt, e.done, e.cnt, e.busy); end
      c++;
      if (c == 10) bus.req = '0;
    end
  endtask
  task automatic test_max_len();
    int c = 0;
    do_reset();
    bus.req = 4'b0010;
    bus.req_len = 16'h00F0;
    for (int i = 0; i < 16; i++) q.push_back(mk(4'b0010, 4'b0000, 4'(i), 1'b1));
    q.push_back(mk(4'b0000, 4'b0010, 4'd0, 1'b0));
    q.push_back(mk(4'b0000, 4'b0000, 4'd0, 1'b0));
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      got = {bus.gnt, bus.done, bus.cnt, bus.busy};
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL max_len cyc %0d got %b_%b_%h_%b required %b_%b_%h_%b", c, got.gnt, got.done, got.cnt, got.busy, e.gnt, e.done, e.cnt, e.busy); end
      c++;
      if (c == 4) bus.req_len = 16'h0020;
      if (c == 17) bus.req = '0;
    end
  endtask
  task automatic test_abort();
    int c = 0;
    do_reset();
    bus.req = 4'b0100;
    bus.req_len = 16'h0700;
    for (int i = 0; i < 3; i++) q.push_back(mk(4'b0100, 4'b0000, 4'(i), 1'b1));
    q.push_back(mk(4'b0000, 4'b0000, 4'd0, 1'b0));
    q.push_back(mk(4'b0000, 4'b0000, 4'd0, 1'b0));
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      got = {bus.gnt, bus.done, bus.cnt, bus.busy};
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL abort cyc %0d got %b_%b_%h_%b required %b_%b_%h_%b", c, got.gnt, got.done, got.cnt, got.busy, e.gnt, e.done, e.cnt, e.busy); end
      c++;
      if (c == 3) bus.req = '0;
    end
    c = 0;
    do_reset();
    bus.req = 4'b0100;
    bus.req_len = 16'h0100;
    q.push_back(mk(4'b0100, 4'b0000, 4'd0, 1'b1));
    q.push_back(mk(4'b0100, 4'b0000, 4'd1, 1'b1));
    q.push_back(mk(4'b0000, 4'b0000, 4'd0, 1'b0));
    q.push_back(mk(4'b0000, 4'b0000, 4'd0, 1'b0));
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      got = {bus.gnt, bus.done, bus.cnt, bus.busy};
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL abort_at_term cyc %0d got %b_%b_%h_%b required %b_%b_%h_%b", c, got.gnt, got.done, got.cnt, got.busy, e.gnt, e.done, e.cnt, e.busy); end
      c++;
      if (c == 2) bus.req = '0;
    end
  endtask
`ifdef COUNTER_SCHED_PAUSE_EN
  task automatic test_pause();
    int c = 0;
    do_reset();
    bus.req = 4'b0001;
    bus.req_len = 16'h0003;
    q.push_back(mk(4'b0001, 4'b0000, 4'd0, 1'b1));
    for (int i = 0; i < 4; i++) q.push_back(mk(4'b0001, 4'b0000, 4'd1, 1'b1));
    q.push_back(mk(4'b0001, 4'b0000, 4'd2, 1'b1));
    q.push_back(mk(4'b0001, 4'b0000, 4'd3, 1'b1));
    q.push_back(mk(4'b0000, 4'b0001, 4'd0, 1'b0));
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      got = {bus.gnt, bus.done, bus.cnt, bus.busy};
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL pause cyc %0d got %b_%b_%h_%b required %b_%b_%h_%b", c, got.gnt, got.done, got.cnt, got.busy, e.gnt, e.done, e.cnt, e.busy); end
      c++;
      if (c == 2) bus.pause = 1'b1;
      if (c == 5) bus.pause = 1'b0;
      if (c == 8) bus.req = '0;
    end
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_max_len();
    test_abort();
`ifdef COUNTER_SCHED_PAUSE_EN
    test_pause();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
